// File: rtl/encode_match_ctl.sv
// encode_match_ctl
//   Match-sequencing controller for the LZS encode datapath. Takes the
//   per-byte stream plus 2-byte hash candidates, extends matches one byte at
//   a time through the history read port, and queues literal / match / end
//   tokens in an internal first-word-fall-through FIFO for the bit packer.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   data         current byte (position iidx), qualified by data_valid
//   data_valid   byte strobe
//   iidx         position i of the current byte
//   cand_hit     bytes at cand_ref/cand_ref+1 equal bytes at i-1/i
//   cand_ref     candidate position
//   data_empty   level: stream has ended, no further data_valid
//   hdata        history read data, one cycle after hraddr
//   hraddr       history read address (combinational)
//   dp_hold      back-pressure to the datapath (registered)
//   tok_valid    token FIFO head valid
//   tok_type     00 literal, 01 match, 11 end
//   tok_val      literal: [7:0] byte; match: {len[7:0], off[10:0]}; end: 0
//   tok_ready    pops the FIFO head when tok_valid
//   ovf_err      sticky: token pushed while FIFO full
//   busy         controller between start of stream and end token

module encode_match_ctl #(
    parameter int unsigned LZF_WIDTH   = 20,
    parameter int unsigned MAX_LEN     = 255,
    parameter int unsigned TOK_DEPTH   = 16,
    parameter int unsigned HOLD_MARGIN = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           data,
    input  logic                 data_valid,
    input  logic [LZF_WIDTH-1:0] iidx,
    input  logic                 cand_hit,
    input  logic [LZF_WIDTH-1:0] cand_ref,
    input  logic                 data_empty,
    input  logic [7:0]           hdata,
    output logic [10:0]          hraddr,
    output logic                 dp_hold,
    output logic                 tok_valid,
    output logic [1:0]           tok_type,
    output logic [18:0]          tok_val,
    input  logic                 tok_ready,
    output logic                 ovf_err,
    output logic                 busy
);

    localparam int unsigned AW = (TOK_DEPTH > 1) ? $clog2(TOK_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0]        DEPTH_C    = CW'(TOK_DEPTH);
    localparam logic [CW-1:0]        HOLD_THR   = CW'(TOK_DEPTH - HOLD_MARGIN);
    localparam logic [7:0]           MAX_LEN_C  = 8'(MAX_LEN);
    localparam logic [LZF_WIDTH-1:0] OFF_MIN    = LZF_WIDTH'(2);
    localparam logic [LZF_WIDTH-1:0] OFF_MAX    = LZF_WIDTH'(2047);

    localparam logic [1:0] T_LIT   = 2'b00;
    localparam logic [1:0] T_MATCH = 2'b01;
    localparam logic [1:0] T_END   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LIT,
        S_MATCH,
        S_FLUSH,
        S_END,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t      state, state_nx;
    logic [7:0]  pending, pending_nx;
    logic [7:0]  len, len_nx;
    logic [10:0] off_r, off_nx;
    logic [10:0] ref_nx, ref_nx_nx;
    logic        flush_match, flush_match_nx;

    logic        push;
    logic [20:0] push_tok;
    logic [10:0] hraddr_c;

    // Candidate offset relative to byte i-1; small offsets would read
    // history bytes not yet written, large ones fall outside the window.
    logic [LZF_WIDTH-1:0] off_full;
    logic [LZF_WIDTH-1:0] ref2;
    logic                 usable;

    assign off_full = iidx - LZF_WIDTH'(1) - cand_ref;
    assign ref2     = cand_ref + LZF_WIDTH'(2);
    assign usable   = cand_hit && (off_full >= OFF_MIN) && (off_full <= OFF_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pending     <= '0;
            len         <= '0;
            off_r       <= '0;
            ref_nx      <= '0;
            flush_match <= 1'b0;
        end else begin
            state       <= state_nx;
            pending     <= pending_nx;
            len         <= len_nx;
            off_r       <= off_nx;
            ref_nx      <= ref_nx_nx;
            flush_match <= flush_match_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        pending_nx     = pending;
        len_nx         = len;
        off_nx         = off_r;
        ref_nx_nx      = ref_nx;
        flush_match_nx = flush_match;
        push           = 1'b0;
        push_tok       = '0;
        hraddr_c       = '0;

        case (state)
            S_IDLE: begin
                if (data_valid) begin
                    pending_nx = data;
                    state_nx   = S_LIT;
                end else if (data_empty) begin
                    state_nx = S_END;
                end
            end

            S_LIT: begin
                if (data_valid) begin
                    if (usable) begin
                        // pending byte becomes the first byte of the match
                        len_nx    = 8'd2;
                        off_nx    = off_full[10:0];
                        ref_nx_nx = ref2[10:0];
                        hraddr_c  = ref2[10:0];
                        state_nx  = S_MATCH;
                    end else begin
                        push       = 1'b1;
                        push_tok   = {T_LIT, 11'd0, pending};
                        pending_nx = data;
                    end
                end else if (data_empty) begin
                    flush_match_nx = 1'b0;
                    state_nx       = S_FLUSH;
                end
            end

            S_MATCH: begin
                hraddr_c = ref_nx;
                if (data_valid) begin
                    if ((hdata == data) && (len < MAX_LEN_C)) begin
                        len_nx    = len + 8'd1;
                        ref_nx_nx = ref_nx + 11'd1;
                        // next compare byte must be requested this cycle
                        hraddr_c  = ref_nx + 11'd1;
                    end else begin
                        push       = 1'b1;
                        push_tok   = {T_MATCH, len, off_r};
                        pending_nx = data;
                        state_nx   = S_LIT;
                    end
                end else if (data_empty) begin
                    flush_match_nx = 1'b1;
                    state_nx       = S_FLUSH;
                end
            end

            S_FLUSH: begin
                push     = 1'b1;
                push_tok = flush_match ? {T_MATCH, len, off_r}
                                       : {T_LIT, 11'd0, pending};
                state_nx = S_END;
            end

            S_END: begin
                push     = 1'b1;
                push_tok = {T_END, 19'd0};
                state_nx = S_DONE;
            end

            S_DONE: begin
                state_nx = S_DONE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign hraddr = hraddr_c;
    assign busy   = (state != S_IDLE) && (state != S_DONE);

    // ------------------------------------------------------------------
    // Token FIFO with registered head
    // ------------------------------------------------------------------
    logic [20:0]   mem [TOK_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
    logic [CW-1:0] count, count_nx, remain;
    logic          pop, full, wr_en, ovf_set;
    logic          head_valid, head_valid_nx;
    logic [20:0]   head, head_nx;
    logic          hold_r, ovf_r;

    assign pop     = head_valid && tok_ready;
    assign full    = (count == DEPTH_C);
    assign wr_en   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    // The head register is reloaded every cycle from the entry that will be
    // at the read pointer; when that entry is the one being pushed right now
    // (FIFO drains to empty this cycle) it is taken straight from push_tok.
    always_comb begin
        rd_ptr_nx = pop ? (rd_ptr + AW'(1)) : rd_ptr;
        remain    = pop ? (count - CW'(1)) : count;
        count_nx  = wr_en ? (remain + CW'(1)) : remain;
        head_nx   = '0;
        if (remain != '0) begin
            head_nx = mem[rd_ptr_nx];
        end else if (wr_en) begin
            head_nx = push_tok;
        end
        head_valid_nx = (count_nx != '0);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_tok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head       <= '0;
            hold_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_ptr_nx;
            count      <= count_nx;
            head_valid <= head_valid_nx;
            head       <= head_nx;
            hold_r     <= (count >= HOLD_THR);
            if (ovf_set) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign tok_valid = head_valid;
    assign tok_type  = head[20:19];
    assign tok_val   = head[18:0];
    assign dp_hold   = hold_r;
    assign ovf_err   = ovf_r;

endmodule

// File: tb/tb_encode_match_ctl.sv
// tb_encode_match_ctl
//   Scoreboard bench for encode_match_ctl: directed byte streams push their
//   expected tokens into a queue; a monitor compares every popped token.

module tb_encode_match_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        data_valid;
    logic [19:0] iidx;
    logic        cand_hit;
    logic [19:0] cand_ref;
    logic        data_empty;
    logic [7:0]  hdata;
    logic [10:0] hraddr;
    logic        dp_hold;
    logic        tok_valid;
    logic [1:0]  tok_type;
    logic [18:0] tok_val;
    logic        tok_ready;
    logic        ovf_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [20:0] exp_q [$];
    logic [7:0]  hist [2048];

    always #5 clk = ~clk;

    encode_match_ctl #(
        .LZF_WIDTH(20),
        .MAX_LEN(255),
        .TOK_DEPTH(16),
        .HOLD_MARGIN(9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data(data),
        .data_valid(data_valid),
        .iidx(iidx),
        .cand_hit(cand_hit),
        .cand_ref(cand_ref),
        .data_empty(data_empty),
        .hdata(hdata),
        .hraddr(hraddr),
        .dp_hold(dp_hold),
        .tok_valid(tok_valid),
        .tok_type(tok_type),
        .tok_val(tok_val),
        .tok_ready(tok_ready),
        .ovf_err(ovf_err),
        .busy(busy)
    );

    // history RAM model: one-cycle registered read
    always @(posedge clk) hdata <= hist[hraddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [20:0] lit(input logic [7:0] b);
        return {2'b00, 11'd0, b};
    endfunction

    function automatic logic [20:0] mtch(input logic [7:0] l, input logic [10:0] o);
        return {2'b01, l, o};
    endfunction

    localparam logic [20:0] END_TOK = {2'b11, 19'd0};

    // monitor: compares every token the DUT hands over
    always @(negedge clk) begin
        if (!rst && tok_valid && tok_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_token", {11'd0, tok_type, tok_val}, 32'h7fff_ffff);
            end else begin
                chk("token", {11'd0, tok_type, tok_val}, {11'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [7:0] b, input int unsigned i, input logic hit,
                         input logic [19:0] cref, input logic ck, input logic [10:0] exp_h);
        data       = b;
        iidx       = 20'(i);
        data_valid = 1'b1;
        cand_hit   = hit;
        cand_ref   = cref;
        #1;
        if (ck) chk("hraddr", {21'd0, hraddr}, {21'd0, exp_h});
        @(posedge clk);
        #2;
        data_valid = 1'b0;
        cand_hit   = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        data_valid = 1'b0;
        cand_hit   = 1'b0;
        data_empty = 1'b0;
        tok_ready  = 1'b1;
        step();
        step();
        exp_q.delete();
        rst = 1'b0;
        step();
    endtask

    task automatic finish_stream(input string name);
        int c;
        data_empty = 1'b1;
        for (c = 0; c < 3000; c++) begin
            if (exp_q.size() == 0 && !busy) break;
            step();
        end
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        step();
        step();
        chk({name, "_no_extra"}, {31'd0, tok_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; data = '0; data_valid = 1'b0; iidx = '0; cand_hit = 1'b0;
        cand_ref = '0; data_empty = 1'b0; tok_ready = 1'b1;
        for (int a = 0; a < 2048; a++) hist[a] = 8'h00;
        #1;
        chk("rst_tok_valid", {31'd0, tok_valid}, 32'd0);
        chk("rst_tok_type",  {30'd0, tok_type}, 32'd0);
        chk("rst_tok_val",   {13'd0, tok_val}, 32'd0);
        chk("rst_dp_hold",   {31'd0, dp_hold}, 32'd0);
        chk("rst_ovf_err",   {31'd0, ovf_err}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_hraddr",    {21'd0, hraddr}, 32'd0);
        do_reset();

        // 1: plain literals
        for (int k = 0; k < 4; k++) begin
            hist[k] = 8'h41 + 8'(k);
            exp_q.push_back(lit(8'h41 + 8'(k)));
        end
        exp_q.push_back(END_TOK);
        for (int k = 0; k < 4; k++) drive(8'h41 + 8'(k), k, 1'b0, '0, 1'b0, '0);
        finish_stream("t1");
        chk("t1_ovf", {31'd0, ovf_err}, 32'd0);
        do_reset();

        // 2: match of length 3 at offset 3
        begin
            logic [7:0] s [7];
            s = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63, 8'h64};
            for (int k = 0; k < 7; k++) hist[k] = s[k];
            exp_q.push_back(lit(8'h61));
            exp_q.push_back(lit(8'h62));
            exp_q.push_back(lit(8'h63));
            exp_q.push_back(mtch(8'd3, 11'd3));
            exp_q.push_back(lit(8'h64));
            exp_q.push_back(END_TOK);
            for (int k = 0; k < 7; k++) begin
                drive(s[k], k, (k == 4), '0, (k == 4 || k == 5),
                      (k == 4) ? 11'd2 : 11'd3);
            end
            finish_stream("t2");
        end
        do_reset();

        // 3: offsets 1, 0 and 2048 are not usable
        for (int k = 0; k < 5; k++) begin
            hist[k] = 8'h70 + 8'(k);
            exp_q.push_back(lit(8'h70 + 8'(k)));
        end
        exp_q.push_back(END_TOK);
        drive(8'h70, 0, 1'b0, 20'd0, 1'b1, 11'd0);
        drive(8'h71, 1, 1'b0, 20'd0, 1'b1, 11'd0);
        drive(8'h72, 2, 1'b1, 20'd0, 1'b1, 11'd0);
        drive(8'h73, 3, 1'b1, 20'd2, 1'b1, 11'd0);
        drive(8'h74, 4, 1'b1, 20'hFF803, 1'b1, 11'd0);
        finish_stream("t3");
        do_reset();

        // 4: long run capped at MAX_LEN, then a fresh match
        for (int k = 0; k < 300; k++) hist[k] = 8'h55;
        exp_q.push_back(lit(8'h55));
        exp_q.push_back(lit(8'h55));
        exp_q.push_back(mtch(8'd255, 11'd2));
        exp_q.push_back(mtch(8'd43, 11'd2));
        exp_q.push_back(END_TOK);
        for (int k = 0; k < 300; k++) begin
            drive(8'h55, k, (k >= 3), (k >= 3) ? 20'(k - 3) : 20'd0, 1'b0, '0);
        end
        finish_stream("t4");
        do_reset();

        // 5: no pops: dp_hold timing and overflow of the 17th token
        tok_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            hist[k] = 8'h10 + 8'(k);
            exp_q.push_back(lit(8'h10 + 8'(k)));
        end
        for (int k = 0; k < 16; k++) begin
            data = 8'h10 + 8'(k); iidx = 20'(k); data_valid = 1'b1;
            @(posedge clk); #1;
            chk("dp_hold_pre", {31'd0, dp_hold}, {31'd0, (k >= 8)});
            data_valid = 1'b0;
            @(posedge clk); #1;
            chk("dp_hold_post", {31'd0, dp_hold}, {31'd0, (k >= 7)});
            #1;
        end
        chk("t5_ovf_before", {31'd0, ovf_err}, 32'd0);
        data_empty = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("t5_ovf_after", {31'd0, ovf_err}, 32'd1);
        chk("t5_hold", {31'd0, dp_hold}, 32'd1);
        tok_ready = 1'b1;
        finish_stream("t5");
        chk("t5_hold_low", {31'd0, dp_hold}, 32'd0);
        do_reset();

        // 6: reset in the middle of a length-5 match
        begin
            logic [7:0] s [10];
            s = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
            for (int k = 0; k < 10; k++) hist[k] = s[k];
            for (int k = 0; k < 5; k++) exp_q.push_back(lit(s[k]));
            for (int k = 0; k < 10; k++) drive(s[k], k, (k == 6), '0, 1'b0, '0);
            chk("t6_busy", {31'd0, busy}, 32'd1);
            chk("t6_hraddr_len5", {21'd0, hraddr}, 32'd5);
            step();
            chk("t6_drained", 32'(exp_q.size()), 32'd0);
            rst = 1'b1;
            #1;
            chk("t6_rst_tok_valid", {31'd0, tok_valid}, 32'd0);
            chk("t6_rst_hraddr", {21'd0, hraddr}, 32'd0);
            chk("t6_rst_dp_hold", {31'd0, dp_hold}, 32'd0);
            chk("t6_rst_busy", {31'd0, busy}, 32'd0);
            #1;
        end
        do_reset();

        // 7: empty stream gives only the end token
        exp_q.push_back(END_TOK);
        finish_stream("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
